// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the streaming N-to-1 multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo NUM_CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  localparam int unsigned SEL_W = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [2*NUM_CH-1:0] req_rot;
  int unsigned         idx;

  always_comb begin
    // Rotating a doubled copy puts the search start at bit 0.
    req_rot = {req, req} >> ptr;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!gnt_vld && req_rot[i]) begin
        gnt_vld = 1'b1;
        idx     = 32'(ptr) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        gnt_idx = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 streaming mux with registered output, fixed-select or round-robin arbitration.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 8,
  localparam int unsigned SEL_W = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_last
);

  mux_mode_e        mode_e;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_last_q;
  logic [SEL_W-1:0] rr_ptr_q;

  logic             arb_vld;
  logic [SEL_W-1:0] arb_idx;
  logic             fixed_vld;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;
  logic             accept;
  logic             xfer;

  assign mode_e = mux_mode_e'(mode);

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    fixed_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) fixed_vld = in_valid[k];
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch_q;
  logic             lock_vld;

  always_comb begin
    lock_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (lock_ch_q == SEL_W'(k)) lock_vld = in_valid[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (xfer) begin
      lock_q    <= !gnt_last;
      lock_ch_q <= gnt_idx;
    end
  end
`endif

  always_comb begin
    if (mode_e == MODE_RR) begin
      gnt_idx = arb_idx;
      gnt_vld = arb_vld;
    end else begin
      gnt_idx = sel;
      gnt_vld = fixed_vld;
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      gnt_idx = lock_ch_q;
      gnt_vld = lock_vld;
    end
`endif
  end

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        gnt_data = in_data[k*WIDTH +: WIDTH];
        gnt_last = in_last[k];
      end
    end
  end

  assign accept = !out_valid_q || out_ready;
  assign xfer   = accept && gnt_vld;

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      in_ready[k] = rst_n && xfer && (gnt_idx == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gnt_data;
        out_ch_q    <= gnt_idx;
        out_last_q  <= gnt_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (xfer && mode_e == MODE_RR) begin
        rr_ptr_q <= (gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: 8-channel instance plus a 5-channel one for select range.
module tb_stream_mux_rr;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_last;

  logic        mode5;
  logic [2:0]  sel5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [39:0] in_data5;
  logic [4:0]  in_last5;
  logic        out_valid5;
  logic        out_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_last5;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_checks;
  int    n_errors;

  stream_mux_rr #(
    .WIDTH  (8),
    .NUM_CH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last)
  );

  stream_mux_rr #(
    .WIDTH  (8),
    .NUM_CH (5)
  ) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode5),
    .sel       (sel5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in_data   (in_data5),
    .in_last   (in_last5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_data  (out_data5),
    .out_ch    (out_ch5),
    .out_last  (out_last5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] ch, input logic [7:0] data, input logic last);
    beat_t b;
    b.ch   = ch;
    b.data = data;
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    in_data[k*8 +: 8] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every accepted output beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_beat", {29'd0, out_ch}, 32'hFFFF_FFFF);
      end else begin
        mon_b = exp_q.pop_front();
        check_val("sb_ch", {29'd0, out_ch}, {29'd0, mon_b.ch});
        check_val("sb_data", {24'd0, out_data}, {24'd0, mon_b.data});
        check_val("sb_last", {31'd0, out_last}, {31'd0, mon_b.last});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    mode       = 1'b0;
    sel        = 3'd3;
    in_valid   = 8'h08;
    in_data    = '0;
    in_last    = '0;
    out_ready  = 1'b1;
    set_data(3, 8'hA5);
    mode5      = 1'b0;
    sel5       = 3'd5;
    in_valid5  = 5'h1F;
    in_data5   = {5{8'h33}};
    in_last5   = '0;
    out_ready5 = 1'b1;

    // Reset state
    #2;
    check_val("rst_in_ready", {24'd0, in_ready}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_data", {24'd0, out_data}, 32'd0);
    check_val("rst_out_ch", {29'd0, out_ch}, 32'd0);
    check_val("rst_out_last", {31'd0, out_last}, 32'd0);
    check_val("rst_in_ready5", {27'd0, in_ready5}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;

    // FIXED sel=3, single beat
    check_val("fixed_in_ready", {24'd0, in_ready}, 32'h08);
    check_val("sel_oob_in_ready5", {27'd0, in_ready5}, 32'd0);
    push_exp(3'd3, 8'hA5, 1'b0);
    step();
    in_valid = 8'h00;
    check_val("fixed_out_valid", {31'd0, out_valid}, 32'd1);
    check_val("sel_oob_out_valid5", {31'd0, out_valid5}, 32'd0);
    step();
    check_val("sel_oob_out_valid5_b", {31'd0, out_valid5}, 32'd0);
    check_val("fixed_drain", {31'd0, out_valid}, 32'd0);

    // 5-channel instance: in-range sel works, out-of-range sel again blocks
    sel5 = 3'd4;
    #1;
    check_val("sel4_in_ready5", {27'd0, in_ready5}, 32'h10);
    step();
    sel5 = 3'd7;
    check_val("sel4_out_valid5", {31'd0, out_valid5}, 32'd1);
    check_val("sel4_out_ch5", {29'd0, out_ch5}, 32'd4);
    check_val("sel4_out_data5", {24'd0, out_data5}, 32'h33);
    #1;
    check_val("sel7_in_ready5", {27'd0, in_ready5}, 32'd0);
    step();
    check_val("sel7_out_valid5", {31'd0, out_valid5}, 32'd0);

    // Reset mid-beat discards the held beat immediately
    in_valid = 8'h08;
    step();
    in_valid = 8'h00;
    check_val("midrst_loaded", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1;

    // RR fairness with all channels valid
    mode = 1'b1;
    for (int k = 0; k < 8; k++) set_data(k, 8'(8'h10 + k));
    for (int i = 0; i < 9; i++) push_exp(3'(i % 8), 8'(8'h10 + (i % 8)), 1'b0);
    in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      check_val("rr_no_bubble", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 8'h00;
    step();
    check_val("rr_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure: rr_ptr is now 1
    push_exp(3'd1, 8'h11, 1'b0);
    in_valid = 8'hFF;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bp_in_ready", {24'd0, in_ready}, 32'd0);
      check_val("bp_out_ch", {29'd0, out_ch}, 32'd1);
      check_val("bp_out_data", {24'd0, out_data}, 32'h11);
      step();
    end
    out_ready = 1'b1;
    push_exp(3'd2, 8'h12, 1'b0);
    #1;
    check_val("bp_release_ready", {24'd0, in_ready}, 32'h04);
    step();
    in_valid = 8'h00;
    check_val("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check_val("bp_next_ch", {29'd0, out_ch}, 32'd2);
    step();
    check_val("bp_idle", {31'd0, out_valid}, 32'd0);

    // RR skip from rr_ptr=0 with ch2 and ch5 valid
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    set_data(2, 8'h22);
    set_data(5, 8'h55);
    push_exp(3'd2, 8'h22, 1'b0);
    push_exp(3'd5, 8'h55, 1'b0);
    push_exp(3'd2, 8'h22, 1'b0);
    in_valid = 8'h24;
    step();
    step();
    step();
    in_valid = 8'h00;
    step();
    step();

    // Packet lock: ch1 sends three beats while ch0 competes
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    set_data(0, 8'hC0);
    push_exp(3'd1, 8'hB0, 1'b0);
`ifdef STREAM_MUX_PKT_LOCK_EN
    push_exp(3'd1, 8'hB1, 1'b0);
    push_exp(3'd1, 8'hB2, 1'b1);
`else
    push_exp(3'd0, 8'hC0, 1'b0);
    push_exp(3'd1, 8'hB2, 1'b1);
`endif
    push_exp(3'd0, 8'hC0, 1'b0);
    set_data(1, 8'hB0);
    in_last  = 8'h00;
    in_valid = 8'h02;
    step();
    set_data(1, 8'hB1);
    in_valid = 8'h03;
    step();
    set_data(1, 8'hB2);
    in_last = 8'h02;
    step();
    in_last  = 8'h00;
    in_valid = 8'h01;
    step();
    in_valid = 8'h00;
    step();
    step();

    check_val("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
